// File: rtl/fft16_peak_detect.sv
// fft16_peak_detect: per-bin power |X|^2 stream plus per-frame peak bin search
// for the natural-order serial bin stream of a 16-point FFT.
module fft16_peak_detect #(
  parameter int unsigned IN_WIDTH = 18,
  parameter int unsigned N_POINT  = 16,
  parameter int unsigned SKIP_DC  = 0
) (
  input  logic                               sys_clk_i,
  input  logic                               rst_i,
  input  logic                               data_in_valid_i,
  input  logic signed [IN_WIDTH-1:0]         xk_real_i,
  input  logic signed [IN_WIDTH-1:0]         xk_imag_i,
  output logic                               pwr_valid_o,
  output logic [2*IN_WIDTH-1:0]              pwr_o,
  output logic [$clog2(N_POINT)-1:0]         pwr_idx_o,
  output logic                               peak_valid_o,
  output logic [$clog2(N_POINT)-1:0]         peak_idx_o,
  output logic [2*IN_WIDTH-1:0]              peak_pwr_o,
  output logic                               frame_err_o
);

  localparam int unsigned IDX_W = $clog2(N_POINT);
  localparam int unsigned PWR_W = 2 * IN_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_POINT - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX = (SKIP_DC != 0) ? IDX_W'(1) : IDX_W'(0);

  typedef enum logic [0:0] {IDLE, COLLECT} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               acc_c;
  logic               abort_c;
  logic               err_q;

  // S1 registers
  logic               s1_vld_q;
  logic [IDX_W-1:0]   s1_idx_q;
  logic [PWR_W-1:0]   re_sq_q, im_sq_q;
  logic signed [PWR_W-1:0] re_ext_c, im_ext_c, re_sq_c, im_sq_c;

  // S2 registers (power stream)
  logic               pwr_vld_q;
  logic [IDX_W-1:0]   pwr_idx_q;
  logic [PWR_W-1:0]   pwr_q;

  // S3 registers (running max and peak result)
  logic [PWR_W-1:0]   max_pwr_q, cand_pwr_c;
  logic [IDX_W-1:0]   max_idx_q, cand_idx_c;
  logic               search_c, take_c, last_c;
  logic               peak_vld_q;
  logic [IDX_W-1:0]   peak_idx_q;
  logic [PWR_W-1:0]   peak_pwr_q;

  // Frame FSM state and bin counter
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= abort_c;
    end
  end

  // Next-state: accept bins, wrap after the last bin, abort on a short burst
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_c   = 1'b0;
    abort_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_in_valid_i) begin
          acc_c   = 1'b1;
          cnt_d   = IDX_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (data_in_valid_i) begin
          acc_c = 1'b1;
          cnt_d = cnt_q + IDX_W'(1);
        end else begin
          abort_c = (cnt_q != '0);
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Sign-extend before squaring so the full 2W-bit product is formed
  always_comb begin
    re_ext_c = PWR_W'(xk_real_i);
    im_ext_c = PWR_W'(xk_imag_i);
    re_sq_c  = re_ext_c * re_ext_c;
    im_sq_c  = im_ext_c * im_ext_c;
  end

  // S1: register squares; in IDLE cnt_q is 0 so it doubles as the bin index
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
      re_sq_q  <= '0;
      im_sq_q  <= '0;
    end else begin
      s1_vld_q <= acc_c;
      s1_idx_q <= cnt_q;
      re_sq_q  <= re_sq_c;
      im_sq_q  <= im_sq_c;
    end
  end

  // S2: power sum; 2^(2W-1) is the largest value and fits without saturation
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      pwr_vld_q <= 1'b0;
      pwr_idx_q <= '0;
      pwr_q     <= '0;
    end else begin
      pwr_vld_q <= s1_vld_q;
      pwr_idx_q <= s1_idx_q;
      pwr_q     <= re_sq_q + im_sq_q;
    end
  end

  // Peak candidate: first searched bin loads, later bins win only if strictly greater
  always_comb begin
    search_c   = pwr_vld_q && !((SKIP_DC != 0) && (pwr_idx_q == '0));
    take_c     = search_c && ((pwr_idx_q == FIRST_IDX) || (pwr_q > max_pwr_q));
    last_c     = pwr_vld_q && (pwr_idx_q == LAST_IDX);
    cand_pwr_c = take_c ? pwr_q : max_pwr_q;
    cand_idx_c = take_c ? pwr_idx_q : max_idx_q;
  end

  // S3: running max and held peak result
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      max_pwr_q  <= '0;
      max_idx_q  <= '0;
      peak_vld_q <= 1'b0;
      peak_idx_q <= '0;
      peak_pwr_q <= '0;
    end else begin
      max_pwr_q  <= cand_pwr_c;
      max_idx_q  <= cand_idx_c;
      peak_vld_q <= last_c;
      if (last_c) begin
        peak_idx_q <= cand_idx_c;
        peak_pwr_q <= cand_pwr_c;
      end
    end
  end

  assign pwr_valid_o  = pwr_vld_q;
  assign pwr_o        = pwr_q;
  assign pwr_idx_o    = pwr_idx_q;
  assign peak_valid_o = peak_vld_q;
  assign peak_idx_o   = peak_idx_q;
  assign peak_pwr_o   = peak_pwr_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_fft16_peak_detect.sv
// Scoreboard bench for fft16_peak_detect: one DUT with DC searched, one with DC skipped.
module tb_fft16_peak_detect;

  logic               clk;
  logic               rst;
  logic               vld;
  logic signed [17:0] xr, xi;

  logic        pwr_valid_o, peak_valid_o, frame_err_o;
  logic [35:0] pwr_o, peak_pwr_o;
  logic [3:0]  pwr_idx_o, peak_idx_o;
  logic        s_pwr_valid_o, s_peak_valid_o, s_frame_err_o;
  logic [35:0] s_pwr_o, s_peak_pwr_o;
  logic [3:0]  s_pwr_idx_o, s_peak_idx_o;

  fft16_peak_detect #(.IN_WIDTH(18), .N_POINT(16), .SKIP_DC(0)) dut (
    .sys_clk_i(clk), .rst_i(rst), .data_in_valid_i(vld),
    .xk_real_i(xr), .xk_imag_i(xi),
    .pwr_valid_o(pwr_valid_o), .pwr_o(pwr_o), .pwr_idx_o(pwr_idx_o),
    .peak_valid_o(peak_valid_o), .peak_idx_o(peak_idx_o), .peak_pwr_o(peak_pwr_o),
    .frame_err_o(frame_err_o)
  );

  fft16_peak_detect #(.IN_WIDTH(18), .N_POINT(16), .SKIP_DC(1)) dut_s (
    .sys_clk_i(clk), .rst_i(rst), .data_in_valid_i(vld),
    .xk_real_i(xr), .xk_imag_i(xi),
    .pwr_valid_o(s_pwr_valid_o), .pwr_o(s_pwr_o), .pwr_idx_o(s_pwr_idx_o),
    .peak_valid_o(s_peak_valid_o), .peak_idx_o(s_peak_idx_o), .peak_pwr_o(s_peak_pwr_o),
    .frame_err_o(s_frame_err_o)
  );

  typedef struct {
    logic [35:0] pwr;
    logic [3:0]  idx;
    int          cyc;
  } pwr_exp_t;

  typedef struct {
    logic [35:0] pwr0;
    logic [3:0]  idx0;
    logic [35:0] pwr1;
    logic [3:0]  idx1;
    int          cyc;
  } peak_exp_t;

  pwr_exp_t  pq[$];
  peak_exp_t kq[$];

  logic signed [17:0] fr_re[16];
  logic signed [17:0] fr_im[16];

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int peak_n = 0;
  int err_n = 0;
  int err_cyc = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  task automatic rand_frame(input int unsigned span);
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = 18'($urandom_range(0, span)) - 18'(span / 2);
      fr_im[i] = 18'($urandom_range(0, span)) - 18'(span / 2);
    end
  endtask

  // Drive n consecutive bins from fr_*; push expected power and (full frames) expected peaks
  task automatic drive_frame(input int n);
    longint p, best0, best1;
    int     bi0, bi1;
    best0 = 0; best1 = 0; bi0 = 0; bi1 = 0;
    for (int i = 0; i < n; i++) begin
      longint r, m;
      pwr_exp_t e;
      @(negedge clk);
      vld = 1'b1;
      xr  = fr_re[i];
      xi  = fr_im[i];
      r = fr_re[i];
      m = fr_im[i];
      p = r * r + m * m;
      e.pwr = 36'(p);
      e.idx = 4'(i);
      e.cyc = cyc + 2;
      pq.push_back(e);
      if (i == 0 || p > best0) begin
        best0 = p; bi0 = i;
      end
      if (i == 1 || (i > 1 && p > best1)) begin
        best1 = p; bi1 = i;
      end
      if (i == 15) begin
        peak_exp_t k;
        k.pwr0 = 36'(best0); k.idx0 = 4'(bi0);
        k.pwr1 = 36'(best1); k.idx1 = 4'(bi1);
        k.cyc  = cyc + 3;
        kq.push_back(k);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld = 1'b0;
      xr  = '0;
      xi  = '0;
    end
  endtask

  // Scoreboard: pop and compare on every output event of both DUTs
  task automatic run_monitor();
    forever begin
      @(negedge clk);
      if (pwr_valid_o || s_pwr_valid_o) begin
        checks++;
        if (pq.size() == 0) begin
          fails++;
          $display("FAIL pwr_unexpected cyc=%0d idx=%0d pwr=%0d s_valid=%0b", cyc, pwr_idx_o, pwr_o, s_pwr_valid_o);
        end else begin
          pwr_exp_t e;
          e = pq.pop_front();
          if (pwr_valid_o !== 1'b1 || s_pwr_valid_o !== 1'b1 || pwr_o !== e.pwr || pwr_idx_o !== e.idx ||
              s_pwr_o !== e.pwr || s_pwr_idx_o !== e.idx || cyc !== e.cyc) begin
            fails++;
            $display("FAIL pwr got idx=%0d pwr=%0d s_idx=%0d s_pwr=%0d cyc=%0d exp idx=%0d pwr=%0d cyc=%0d",
                     pwr_idx_o, pwr_o, s_pwr_idx_o, s_pwr_o, cyc, e.idx, e.pwr, e.cyc);
          end
        end
      end
      if (peak_valid_o || s_peak_valid_o) begin
        checks++;
        peak_n++;
        if (kq.size() == 0) begin
          fails++;
          $display("FAIL peak_unexpected cyc=%0d idx=%0d pwr=%0d", cyc, peak_idx_o, peak_pwr_o);
        end else begin
          peak_exp_t k;
          k = kq.pop_front();
          if (peak_valid_o !== 1'b1 || s_peak_valid_o !== 1'b1 || peak_idx_o !== k.idx0 || peak_pwr_o !== k.pwr0 ||
              s_peak_idx_o !== k.idx1 || s_peak_pwr_o !== k.pwr1 || cyc !== k.cyc) begin
            fails++;
            $display("FAIL peak got idx=%0d pwr=%0d s_idx=%0d s_pwr=%0d cyc=%0d exp idx=%0d pwr=%0d s_idx=%0d s_pwr=%0d cyc=%0d",
                     peak_idx_o, peak_pwr_o, s_peak_idx_o, s_peak_pwr_o, cyc,
                     k.idx0, k.pwr0, k.idx1, k.pwr1, k.cyc);
          end
        end
      end
      if (frame_err_o) begin
        err_n++;
        err_cyc = cyc;
      end
      if (frame_err_o !== s_frame_err_o) begin
        checks++;
        fails++;
        $display("FAIL err_pair got=%0b s=%0b cyc=%0d", frame_err_o, s_frame_err_o, cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; xr = '0; xi = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwr_valid_o, pwr_o, pwr_idx_o, peak_valid_o, peak_idx_o, peak_pwr_o, frame_err_o} !== '0 ||
        {s_pwr_valid_o, s_peak_valid_o, s_peak_pwr_o, s_frame_err_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got pwr=%0d idx=%0d peak=%0d/%0d required all 0", pwr_o, pwr_idx_o, peak_idx_o, peak_pwr_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_bin();
    clear_frame();
    fr_re[5] = 18'sd3; fr_im[5] = 18'sd4;
    drive_frame(16);
    idle(8);
    checks++;
    if (peak_idx_o !== 4'd5 || peak_pwr_o !== 36'd25) begin
      fails++;
      $display("FAIL peak_hold got idx=%0d pwr=%0d required idx=5 pwr=25", peak_idx_o, peak_pwr_o);
    end
  endtask

  task automatic test_max_negative();
    clear_frame();
    fr_re[9] = -18'sd131072; fr_im[9] = -18'sd131072;
    drive_frame(16);
    idle(6);
  endtask

  task automatic test_tie();
    clear_frame();
    fr_re[3] = 18'sd10; fr_re[11] = 18'sd10;
    drive_frame(16);
    idle(6);
  endtask

  task automatic test_skip_dc();
    clear_frame();
    fr_re[0] = 18'sd100; fr_re[2] = 18'sd1; fr_im[2] = 18'sd1;
    drive_frame(16);
    idle(6);
  endtask

  task automatic test_abort();
    int p0, low_cyc;
    p0 = peak_n;
    rand_frame(200);
    drive_frame(7);
    @(negedge clk);
    vld = 1'b0;
    low_cyc = cyc;
    idle(6);
    checks++;
    if (err_n !== 1 || err_cyc !== low_cyc + 1 || peak_n !== p0) begin
      fails++;
      $display("FAIL abort got errs=%0d err_cyc=%0d peaks=%0d required errs=1 err_cyc=%0d peaks=%0d",
               err_n, err_cyc, peak_n, low_cyc + 1, p0);
    end
    rand_frame(200);
    drive_frame(16);
    idle(6);
    checks++;
    if (peak_n !== p0 + 1 || err_n !== 1) begin
      fails++;
      $display("FAIL after_abort got peaks=%0d errs=%0d required peaks=%0d errs=1", peak_n, err_n, p0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = peak_n;
    rand_frame(6);
    drive_frame(16);
    rand_frame(6);
    drive_frame(16);
    rand_frame(6);
    drive_frame(8);
    @(negedge clk);
    rst = 1'b1;
    vld = 1'b1;
    xr  = fr_re[8];
    xi  = fr_im[8];
    @(posedge clk);
    #1;
    pq.delete();
    checks++;
    if (peak_n !== p0 + 2) begin
      fails++;
      $display("FAIL b2b_peaks got=%0d required=%0d", peak_n - p0, 2);
    end
    checks++;
    if ({pwr_valid_o, pwr_o, pwr_idx_o, peak_valid_o, peak_idx_o, peak_pwr_o, frame_err_o} !== '0 ||
        {s_pwr_valid_o, s_peak_valid_o, s_peak_idx_o, s_peak_pwr_o, s_frame_err_o} !== '0) begin
      fails++;
      $display("FAIL midframe_reset got pwr_v=%0b peak=%0d/%0d err=%0b required all 0",
               pwr_valid_o, peak_idx_o, peak_pwr_o, frame_err_o);
    end
    idle(2);
    rst = 1'b0;
    idle(8);
    checks++;
    if (peak_n !== p0 + 2 || err_n !== 1) begin
      fails++;
      $display("FAIL post_reset_quiet got peaks=%0d errs=%0d required peaks=%0d errs=1", peak_n, err_n, p0 + 2);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      rand_frame((f % 2 == 0) ? 4 : 4000);
      drive_frame(16);
    end
    idle(8);
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_single_bin();
    test_max_negative();
    test_tie();
    test_skip_dc();
    test_abort();
    test_random();
    test_back_to_back();
    checks++;
    if (pq.size() != 0 || kq.size() != 0) begin
      fails++;
      $display("FAIL drain got pending_pwr=%0d pending_peak=%0d required 0 0", pq.size(), kq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
